masked_share_encoder: RTL and testbench
=======================================

Name: masked_share_encoder

Overview:
- Entry stage of the masked datapath: turns an unmasked WIDTH-bit value into a Boolean sharing using fresh randomness.
- Output layout lets each lane drive a sharewise masked XOR (or any NUM_SHARES gadget) directly.
- Single register stage followed by a 2-entry output buffer.
- Valid/ready handshakes on the data input, the randomness input and the shares output.

Parameters:
- NUM_SHARES, 2, number of shares per bit (>= 2).
- WIDTH, 8, number of unmasked bits (lanes) per transfer (>= 1).

Ports:
- in_clock  input  1  clock, rising edge.
- in_reset_n  input  1  asynchronous reset, active-low.
- in_data  input  WIDTH  unmasked value.
- in_data_valid  input  1  in_data is valid.
- out_data_ready  output  1  data can be accepted this cycle.
- in_rand  input  WIDTH*(NUM_SHARES-1)  fresh randomness. Lane i, mask j (j=1..NUM_SHARES-1) is at bit i*(NUM_SHARES-1)+(j-1).
- in_rand_valid  input  1  in_rand is valid.
- out_rand_ready  output  1  randomness can be consumed this cycle.
- out_shares  output  WIDTH*NUM_SHARES  shared value. Lane i occupies [i*NUM_SHARES +: NUM_SHARES].
- out_shares_valid  output  1  out_shares holds a valid entry.
- in_shares_ready  input  1  downstream accepts out_shares.

Behaviour:
- Encoding, per lane i:
  - Share j (j>=1) = mask j.
  - Share 0 = in_data[i] XOR all masks of lane i.
  - The XOR of all shares of lane i equals in_data[i].
- Share 0 is computed combinationally and registered on push. No unregistered path exists from in_data or in_rand to out_shares.
- Join handshake:
  - out_data_ready = !full & in_rand_valid.
  - out_rand_ready = !full & in_data_valid.
  - push = in_data_valid & in_rand_valid & !full.
  - Data and randomness are consumed together, exactly on push. Neither is consumed alone.
  - The combinational dependence of each ready on the other side's valid is intentional. Upstream valids must not depend on these readys.
- pop = out_shares_valid & in_shares_ready.
- Buffer: 2 entries (head, tail), occupancy count 0..2, full = (count==2).
  - out_shares is driven from the head register.
  - out_shares_valid = (count != 0).
  - Buffer states and transitions:
    - EMPTY, push -> ONE. Entry written to head.
    - ONE:
      - push & !pop -> FULL. Entry written to tail.
      - pop & !push -> EMPTY.
      - push & pop -> ONE. New entry written to head.
    - FULL:
      - pop -> ONE. Tail moves to head.
      - push is impossible while full.
- Latency: push in cycle t gives out_shares_valid in cycle t+1 when the buffer was empty or popped in t.
- Throughput: one transfer per cycle with in_shares_ready held high.
- Output must stay stable while out_shares_valid & !in_shares_ready.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, head/tail shares=0, out_shares_valid=0, out_shares=0.
  - out_data_ready=0 and out_rand_ready=0 while in_reset_n is low.
  - Entries in flight are discarded.
- Popped entries are not cleared. Each mask value is used for exactly one pushed entry.

Test Plan:
- NUM_SHARES=2, WIDTH=4, in_data=0xA, in_rand=0x3, both valid, in_shares_ready=1 -> next cycle out_shares_valid=1. Share1 bits per lane = 0x3, share0 bits = 0x9; lane XOR = 0xA. out_data_ready stays 1.
- in_data_valid=1, in_rand_valid=0 for 3 cycles, then rand valid -> out_data_ready=0 while rand invalid. Exactly one push in the 4th cycle, one output entry.
- in_shares_ready=0, push 0x1, 0x2, 0x3 on consecutive cycles -> 0x1, 0x2 stored, full after the second push. out_data_ready=0 and out_rand_ready=0; 0x3 held upstream. out_shares is stable (0x1) until ready.
- Stall release: from full, in_shares_ready=1 -> pops yield 0x1, then 0x2, then 0x3 in order, each reconstructing correctly with no duplication.
- NUM_SHARES=3, WIDTH=1, in_data=1, in_rand=2'b10 -> shares {1,0,0}. XOR=1, share0=1^0^1=0.
- Assert in_reset_n=0 mid-cycle with count=2 -> out_shares_valid=0 and out_shares=0 immediately. After release, the next push works from EMPTY.

Source files
------------

// File: rtl/masked_share_encoder.sv
// ----------------------------------------------------------------------------
// masked_share_encoder
//
// Entry stage of the masked datapath. Each unmasked bit (lane) is split into
// NUM_SHARES Boolean shares using fresh randomness:
//   share j (j>=1) = mask j
//   share 0        = data bit XOR all masks of that lane
// The encoded word is registered on push into a 2-entry output buffer
// (head/tail). out_shares is always driven from the head register, so there
// is no combinational path from in_data/in_rand to out_shares.
//
// Ports:
//   in_clock          clock, rising edge
//   in_reset_n        asynchronous reset, active-low
//   in_data           unmasked value, WIDTH bits
//   in_data_valid     in_data is valid
//   out_data_ready    data accepted this cycle (needs rand valid and room)
//   in_rand           masks, lane i mask j at bit i*(NUM_SHARES-1)+(j-1)
//   in_rand_valid     in_rand is valid
//   out_rand_ready    randomness consumed this cycle (needs data valid and room)
//   out_shares        lane i at [i*NUM_SHARES +: NUM_SHARES], share 0 at LSB
//   out_shares_valid  head entry is valid
//   in_shares_ready   downstream accepts out_shares
// ----------------------------------------------------------------------------
module masked_share_encoder #(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                              in_clock,
    input  logic                              in_reset_n,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic                              in_data_valid,
    output logic                              out_data_ready,
    input  logic [WIDTH*(NUM_SHARES-1)-1:0]   in_rand,
    input  logic                              in_rand_valid,
    output logic                              out_rand_ready,
    output logic [WIDTH*NUM_SHARES-1:0]       out_shares,
    output logic                              out_shares_valid,
    input  logic                              in_shares_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;

    logic [WIDTH*NUM_SHARES-1:0]   w_enc;
    logic [WIDTH*NUM_SHARES-1:0]   r_head;
    logic [WIDTH*NUM_SHARES-1:0]   r_tail;

    logic                          w_full;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_head_from_enc;
    logic                          w_head_from_tail;
    logic                          w_tail_from_enc;

    // ------------------------------------------------------------------
    // Share encoding: masks pass straight through as shares 1..N-1,
    // share 0 absorbs the data bit and every mask of the lane.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        logic [NUM_SHARES-2:0] w_masks;
        assign w_masks = in_rand[gi*(NUM_SHARES-1) +: (NUM_SHARES-1)];
        assign w_enc[gi*NUM_SHARES +: NUM_SHARES] = {w_masks, in_data[gi] ^ (^w_masks)};
    end

    // ------------------------------------------------------------------
    // Join handshake: data and randomness are only ever consumed together.
    // Readies are forced low while reset is asserted.
    // ------------------------------------------------------------------
    assign w_full         = (r_state == ST_FULL);
    assign w_push         = in_data_valid & in_rand_valid & ~w_full;
    assign w_pop          = out_shares_valid & in_shares_ready;
    assign out_data_ready = in_reset_n & ~w_full & in_rand_valid;
    assign out_rand_ready = in_reset_n & ~w_full & in_data_valid;

    assign out_shares       = r_head;
    assign out_shares_valid = (r_state != ST_EMPTY);

    // ------------------------------------------------------------------
    // Buffer occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_head_from_enc  = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_from_enc  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_next    = ST_ONE;
                    w_head_from_enc = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    // Head leaves and the new entry replaces it in place.
                    w_head_from_enc = 1'b1;
                end else if (w_push) begin
                    w_state_next    = ST_FULL;
                    w_tail_from_enc = 1'b1;
                end else if (w_pop) begin
                    w_state_next    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // No push can occur while full; only the tail shift remains.
                if (w_pop) begin
                    w_state_next     = ST_ONE;
                    w_head_from_tail = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Entry storage. Popped entries are not cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_head_from_enc) begin
                r_head <= w_enc;
            end else if (w_head_from_tail) begin
                r_head <= r_tail;
            end
            if (w_tail_from_enc) begin
                r_tail <= w_enc;
            end
        end
    end

endmodule

// File: tb/tb_masked_share_encoder.sv
module tb_masked_share_encoder;

    logic clk;
    logic rst_n;

    // DUT A: NUM_SHARES=2, WIDTH=4
    logic [3:0] a_data;
    logic       a_dv;
    logic       a_dr;
    logic [3:0] a_rand;
    logic       a_rv;
    logic       a_rr;
    logic [7:0] a_sh;
    logic       a_sv;
    logic       a_sready;

    // DUT B: NUM_SHARES=3, WIDTH=1
    logic [0:0] b_data;
    logic       b_dv;
    logic       b_dr;
    logic [1:0] b_rand;
    logic       b_rv;
    logic       b_rr;
    logic [2:0] b_sh;
    logic       b_sv;
    logic       b_sready;

    int errors = 0;
    int checks = 0;

    masked_share_encoder #(.NUM_SHARES(2), .WIDTH(4)) u_dut_a (
        .in_clock         (clk),
        .in_reset_n       (rst_n),
        .in_data          (a_data),
        .in_data_valid    (a_dv),
        .out_data_ready   (a_dr),
        .in_rand          (a_rand),
        .in_rand_valid    (a_rv),
        .out_rand_ready   (a_rr),
        .out_shares       (a_sh),
        .out_shares_valid (a_sv),
        .in_shares_ready  (a_sready)
    );

    masked_share_encoder #(.NUM_SHARES(3), .WIDTH(1)) u_dut_b (
        .in_clock         (clk),
        .in_reset_n       (rst_n),
        .in_data          (b_data),
        .in_data_valid    (b_dv),
        .out_data_ready   (b_dr),
        .in_rand          (b_rand),
        .in_rand_valid    (b_rv),
        .out_rand_ready   (b_rr),
        .out_shares       (b_sh),
        .out_shares_valid (b_sv),
        .in_shares_ready  (b_sready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding straight from the sharing rules.
    function automatic logic [63:0] model_encode(int ns, int w, logic [31:0] d, logic [63:0] r);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < w; i++) begin
            logic acc;
            acc = d[i];
            for (int j = 1; j < ns; j++) begin
                res[i*ns + j] = r[i*(ns-1) + j - 1];
                acc = acc ^ r[i*(ns-1) + j - 1];
            end
            res[i*ns] = acc;
        end
        return res;
    endfunction

    // Unmask: XOR of all shares per lane.
    function automatic logic [31:0] model_decode(int ns, int w, logic [63:0] s);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < w; i++) begin
            for (int j = 0; j < ns; j++) begin
                d[i] = d[i] ^ s[i*ns + j];
            end
        end
        return d;
    endfunction

    typedef struct {
        logic [3:0] data;
        logic [3:0] rnd;
        logic [7:0] exp;
    } vec_t;

    vec_t        vecs [6];
    logic [7:0]  q [$];
    logic [3:0]  stall_rnd [3];
    logic        m_push;
    logic        m_pop;

    initial begin
        vecs[0] = '{data: 4'h0, rnd: 4'h0, exp: 8'h00};
        vecs[1] = '{data: 4'hF, rnd: 4'h0, exp: 8'h55};
        vecs[2] = '{data: 4'h0, rnd: 4'hF, exp: 8'hFF};
        vecs[3] = '{data: 4'hF, rnd: 4'hF, exp: 8'hAA};
        vecs[4] = '{data: 4'hA, rnd: 4'h3, exp: 8'h4B};
        vecs[5] = '{data: 4'h5, rnd: 4'h6, exp: 8'h2D};
        stall_rnd[0] = 4'hC;
        stall_rnd[1] = 4'h5;
        stall_rnd[2] = 4'hE;

        // Reset with valids asserted: outputs cleared, readies held low.
        rst_n = 1'b0;
        a_data = '0; a_rand = '0; a_dv = 1'b1; a_rv = 1'b1; a_sready = 1'b1;
        b_data = '0; b_rand = '0; b_dv = 1'b1; b_rv = 1'b1; b_sready = 1'b1;
        #3;
        check("rst_a_valid", 64'(a_sv), 64'd0);
        check("rst_a_shares", 64'(a_sh), 64'd0);
        check("rst_a_dready", 64'(a_dr), 64'd0);
        check("rst_a_rready", 64'(a_rr), 64'd0);
        check("rst_b_valid", 64'(b_sv), 64'd0);
        check("rst_b_dready", 64'(b_dr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        a_dv = 1'b0; a_rv = 1'b0; b_dv = 1'b0; b_rv = 1'b0;
        rst_n = 1'b1;

        // Table vectors, back-to-back with downstream always ready.
        a_sready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("tbl_valid", 64'(a_sv), 64'd1);
                check("tbl_shares", 64'(a_sh), 64'(vecs[i-1].exp));
            end
            a_data = vecs[i].data; a_rand = vecs[i].rnd; a_dv = 1'b1; a_rv = 1'b1;
            #1;
            check("tbl_dready", 64'(a_dr), 64'd1);
            check("tbl_rready", 64'(a_rr), 64'd1);
        end
        @(negedge clk);
        check("tbl_valid", 64'(a_sv), 64'd1);
        check("tbl_shares", 64'(a_sh), 64'(vecs[5].exp));
        check("tbl_recon", 64'(model_decode(2, 4, 64'(a_sh))), 64'h5);
        a_dv = 1'b0; a_rv = 1'b0;
        @(negedge clk);
        check("tbl_drain", 64'(a_sv), 64'd0);

        // Randomness withheld for three cycles: nothing consumed.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_data = 4'h6; a_rand = 4'h9; a_dv = 1'b1; a_rv = 1'b0;
            #1;
            check("join_dready_low", 64'(a_dr), 64'd0);
            check("join_rready_high", 64'(a_rr), 64'd1);
            check("join_no_push", 64'(a_sv), 64'd0);
        end
        @(negedge clk);
        a_rv = 1'b1;
        #1;
        check("join_dready", 64'(a_dr), 64'd1);
        @(negedge clk);
        check("join_valid", 64'(a_sv), 64'd1);
        check("join_shares", 64'(a_sh), model_encode(2, 4, 32'h6, 64'h9));
        a_dv = 1'b0; a_rv = 1'b0;
        @(negedge clk);
        check("join_single", 64'(a_sv), 64'd0);

        // Output stall: fill, hold third entry upstream, then release.
        a_sready = 1'b0;
        @(negedge clk);
        a_data = 4'h1; a_rand = stall_rnd[0]; a_dv = 1'b1; a_rv = 1'b1;
        @(negedge clk);
        check("stall_valid", 64'(a_sv), 64'd1);
        check("stall_head1", 64'(a_sh), model_encode(2, 4, 32'h1, 64'(stall_rnd[0])));
        a_data = 4'h2; a_rand = stall_rnd[1];
        #1;
        check("stall_dready_one", 64'(a_dr), 64'd1);
        @(negedge clk);
        check("stall_head1", 64'(a_sh), model_encode(2, 4, 32'h1, 64'(stall_rnd[0])));
        a_data = 4'h3; a_rand = stall_rnd[2];
        #1;
        check("stall_dready_full", 64'(a_dr), 64'd0);
        check("stall_rready_full", 64'(a_rr), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_hold", 64'(a_sh), model_encode(2, 4, 32'h1, 64'(stall_rnd[0])));
            check("stall_hold_dready", 64'(a_dr), 64'd0);
        end
        @(negedge clk);
        a_sready = 1'b1;
        #1;
        check("release_dready_full", 64'(a_dr), 64'd0);
        check("release_recon1", 64'(model_decode(2, 4, 64'(a_sh))), 64'h1);
        @(negedge clk);
        check("release_head2", 64'(a_sh), model_encode(2, 4, 32'h2, 64'(stall_rnd[1])));
        check("release_recon2", 64'(model_decode(2, 4, 64'(a_sh))), 64'h2);
        #1;
        check("release_dready", 64'(a_dr), 64'd1);
        @(negedge clk);
        check("release_head3", 64'(a_sh), model_encode(2, 4, 32'h3, 64'(stall_rnd[2])));
        check("release_recon3", 64'(model_decode(2, 4, 64'(a_sh))), 64'h3);
        a_dv = 1'b0; a_rv = 1'b0;
        @(negedge clk);
        check("release_empty", 64'(a_sv), 64'd0);

        // Asynchronous reset while full, then restart from empty.
        a_sready = 1'b0;
        @(negedge clk);
        a_data = 4'h7; a_rand = 4'h1; a_dv = 1'b1; a_rv = 1'b1;
        @(negedge clk);
        a_data = 4'h8; a_rand = 4'h2;
        @(negedge clk);
        check("arst_full_valid", 64'(a_sv), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(a_sv), 64'd0);
        check("arst_shares", 64'(a_sh), 64'd0);
        check("arst_dready", 64'(a_dr), 64'd0);
        check("arst_rready", 64'(a_rr), 64'd0);
        @(negedge clk);
        check("arst_hold", 64'(a_sv), 64'd0);
        rst_n = 1'b1;
        a_data = 4'h5; a_rand = 4'h6; a_sready = 1'b1;
        #1;
        check("arst_restart_dready", 64'(a_dr), 64'd1);
        @(negedge clk);
        check("arst_restart_valid", 64'(a_sv), 64'd1);
        check("arst_restart_shares", 64'(a_sh), 64'h2D);
        a_dv = 1'b0; a_rv = 1'b0;
        @(negedge clk);
        check("arst_restart_drain", 64'(a_sv), 64'd0);

        // Three-share instance: hand vector then all input combinations.
        b_sready = 1'b1;
        @(negedge clk);
        b_data = 1'b1; b_rand = 2'b10; b_dv = 1'b1; b_rv = 1'b1;
        @(negedge clk);
        check("b_valid", 64'(b_sv), 64'd1);
        check("b_shares", 64'(b_sh), 64'b100);
        for (int c = 0; c < 8; c++) begin
            b_data = 1'(c >> 2); b_rand = 2'(c);
            @(negedge clk);
            check("b_sweep", 64'(b_sh), model_encode(3, 1, 32'(c >> 2), 64'(c & 3)));
            check("b_sweep_recon", 64'(model_decode(3, 1, 64'(b_sh))), 64'(c >> 2));
        end
        b_dv = 1'b0; b_rv = 1'b0;
        @(negedge clk);
        check("b_drain", 64'(b_sv), 64'd0);

        // Randomized traffic against a queue model of the 2-entry buffer.
        q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            check("rnd_valid", 64'(a_sv), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("rnd_shares", 64'(a_sh), 64'(q[0]));
            end
            a_data   = 4'($urandom);
            a_rand   = 4'($urandom);
            a_dv     = ($urandom_range(0, 3) != 0);
            a_rv     = ($urandom_range(0, 3) != 0);
            a_sready = ($urandom_range(0, 2) != 0);
            #1;
            check("rnd_dready", 64'(a_dr), 64'((q.size() < 2) && a_rv));
            check("rnd_rready", 64'(a_rr), 64'((q.size() < 2) && a_dv));
            m_push = a_dv && a_rv && (q.size() < 2);
            m_pop  = (q.size() != 0) && a_sready;
            if (m_pop) begin
                void'(q.pop_front());
            end
            if (m_push) begin
                q.push_back(8'(model_encode(2, 4, 32'(a_data), 64'(a_rand))));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
